i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

I2C target-side (responder) bit engine for the `wb_i2c` subsystem. It is the far end of the bus driven by the SCL generator/master: it samples the externally driven SCL/SDA lines, detects START/STOP, matches a 7-bit address, ACKs, and receives or transmits bytes MSB-first through a simple byte handshake. SDA is driven open-drain through an enable. The block never drives SCL and does not stretch the clock.

## Interface
- `ADDR`, 7'h3C: responder 7-bit address.
- `FILT`, 4: glitch-filter depth in `clk` cycles (1..15).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `scl_in` in 1: raw SCL pad input (asynchronous).
- `sda_in` in 1: raw SDA pad input (asynchronous).
- `sda_oe` out 1: 1 = pull SDA low. The pad is `sda_oe ? 1'b0 : 1'bz`.
- `rx_data` out 8: last received data byte. Held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_ready` in 1: sampled at byte completion. 1 = ACK the byte, 0 = NACK it.
- `tx_data` in 8: next byte to transmit. Must be stable when `tx_req` pulses.
- `tx_req` out 1: one-cycle pulse when `tx_data` is loaded into the shifter.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `busy` out 1: 1 while addressed, from address ACK until STOP or START.

## Operation
- **Input conditioning**
  - Each line passes through a 2-FF synchronizer, then a filter.
  - The filtered value (`scl_f`, `sda_f`) changes only after the synchronized value has differed from it for `FILT` consecutive cycles.
  - Both filtered values reset to 1.
  - Edge flags `scl_rise`/`scl_fall` are derived from `scl_f`, each one cycle wide.
- **Bus conditions** (override every state)
  - START: `sda_f` falls while `scl_f` = 1. Pulse `start_det`, clear the bit counter, go to ADDR, release SDA.
  - STOP: `sda_f` rises while `scl_f` = 1. Pulse `stop_det`, go to IDLE, release SDA, clear `busy`.
- **States**
  - IDLE: `sda_oe` = 0. Wait for START.
  - ADDR: shift `sda_f` on each `scl_rise`; bit counter 0..7.
    - On the 8th rise, compare bits[7:1] with `ADDR`.
    - Match: latch R/W, go to ADDR_ACK.
    - Mismatch: go to IDLE (ignore traffic until the next START).
  - ADDR_ACK:
    - On the next `scl_fall`, set `sda_oe` = 1 and set `busy`.
    - On the following `scl_fall`, release SDA.
    - R/W = 0: go to RX.
    - R/W = 1: load `tx_data`, pulse `tx_req`, drive bit 7, go to TX.
  - RX: shift on `scl_rise`.
    - On the 8th rise: update `rx_data`, pulse `rx_valid` the next cycle, latch `rx_ready`, go to RX_ACK.
  - RX_ACK:
    - On `scl_fall`, set `sda_oe` = latched `rx_ready`.
    - On the next `scl_fall`, release SDA and go to RX.
  - TX:
    - `sda_oe` = ~current bit.
    - On each `scl_fall`, advance to the next bit.
    - After the 8th fall, release SDA and go to TX_ACK.
  - TX_ACK:
    - On `scl_rise`, sample `sda_f`.
    - 0 (master ACK): on the next `scl_fall`, load `tx_data`, pulse `tx_req`, drive bit 7, go to TX.
    - 1 (NACK): go to TX_DONE.
  - TX_DONE: `sda_oe` = 0. Wait for STOP or START.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- A START detected while `sda_oe` = 1 cannot occur legally. The block still handles it by releasing SDA immediately.

## Timing
- Pad-to-filtered latency is exactly 2 + `FILT` cycles.
- `sda_oe` changes are registered: they take effect 1 cycle after the `scl_fall` flag, i.e. 3 + `FILT` cycles after the pad edge. This gives data hold time after the SCL fall.
- `rx_valid` asserts 1 cycle after the 8th `scl_rise` flag.
- `tx_req` asserts in the same cycle the shifter loads.
- Simultaneous START/STOP and `scl` edge in one cycle: START/STOP wins.
- Reset values: state IDLE, `sda_oe` 0, `rx_data` 8'h00, `rx_valid` 0, `tx_req` 0, `start_det` 0, `stop_det` 0, `busy` 0, shifters 0, bit counter 0.
- Reset mid-transfer releases SDA asynchronously. After reset, the block waits for a fresh START.
- SCL high/low phases must each exceed 2·`FILT` + 4 cycles. Slower rates are unrestricted; the 40000-cycle phases of the existing master are fine.

## Test plan
- **Write, match:** START, 0x78 (0x3C, W), data 0xA5, STOP, with `rx_ready` = 1.
  - Required: SDA low on both 9th clocks.
  - Required: `rx_valid` pulses once with `rx_data` = 0xA5.
  - Required: `start_det` and `stop_det` each pulse once; `busy` high between them.
- **Address mismatch:** START, 0x52, data 0xFF.
  - Required: `sda_oe` stays 0 throughout, no `rx_valid`, `busy` stays 0.
- **Read:** START, 0x79, `tx_data` = 0x3C then 0xC3; master ACKs byte 1, NACKs byte 2.
  - Required: SDA carries 0x3C then 0xC3; `tx_req` pulses twice.
  - Required: SDA released after the NACK, state TX_DONE until STOP.
- **Repeated START:** write 0x78 and 0x11, then Sr, then 0x79 and read one byte.
  - Required: `start_det` pulses twice; direction switches with no STOP in between.
- **Glitch and NACK:** a 2-cycle SDA low pulse while SCL is high (`FILT` = 4), then write with `rx_ready` = 0.
  - Required: no `start_det` for the glitch.
  - Required: 9th-clock SDA stays high (NACK), but `rx_valid` still pulses.
- **Reset mid-transfer:** assert `reset` while `sda_oe` = 1 during an ACK.
  - Required: `sda_oe` = 0 without waiting for a clock edge.
  - Required: subsequent bits are ignored until a new START.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target-side bit engine: filtered SCL/SDA sampling, START/STOP detection,
// 7-bit address match with ACK, and MSB-first byte receive/transmit via a byte handshake.
module i2c_slave_responder #(
    parameter logic [6:0]  ADDR = 7'h3C,
    parameter int unsigned FILT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX       = 3'd5,
        S_TX_ACK   = 3'd6,
        S_TX_DONE  = 3'd7
    } state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [6:0] tx_shift_q;
    logic       rw_q, ack_q, phase_q;
    logic       sda_oe_q, rx_valid_q, tx_req_q, start_det_q, stop_det_q, busy_q;
    logic [7:0] rx_data_q;

    // The filtered level follows the synchronized one only after FILT consecutive differing cycles.
    function automatic logic [4:0] filt_next(input logic raw, input logic filt, input logic [3:0] cnt);
        logic [4:0] r;
        r = {filt, 4'd0};
        if (raw != filt) begin
            if (cnt == FILT_LAST) begin
                r = {raw, 4'd0};
            end else begin
                r = {filt, cnt + 4'd1};
            end
        end else begin
            r = {filt, 4'd0};
        end
        return r;
    endfunction

    // Next-state of both glitch filters.
    always_comb begin
        {scl_f_d, scl_cnt_d} = filt_next(scl_sync_q[1], scl_f_q, scl_cnt_q);
        {sda_f_d, sda_cnt_d} = filt_next(sda_sync_q[1], sda_f_q, sda_cnt_q);
    end

    // Synchronizers, filters and previous-level registers for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= 4'd0;
            sda_cnt_q  <= 4'd0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    assign scl_rise_s = scl_f_q & ~scl_prev_q;
    assign scl_fall_s = ~scl_f_q & scl_prev_q;
    assign start_s    = scl_f_q & sda_prev_q & ~sda_f_q;
    assign stop_s     = scl_f_q & ~sda_prev_q & sda_f_q;

    // Protocol FSM; START/STOP take priority over any SCL edge seen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            tx_shift_q  <= 7'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            phase_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            if (start_s) begin
                start_det_q <= 1'b1;
                bit_cnt_q   <= 3'd0;
                phase_q     <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= S_ADDR;
            end else if (stop_s) begin
                stop_det_q <= 1'b1;
                phase_q    <= 1'b0;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: sda_oe_q <= 1'b0;
                    S_ADDR: if (scl_rise_s) begin
                        shift_q   <= {shift_q[5:0], sda_f_q};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == ADDR) begin
                                rw_q    <= sda_f_q;
                                phase_q <= 1'b0;
                                state_q <= S_ADDR_ACK;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall_s) begin
                        if (!phase_q) begin
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            phase_q  <= 1'b1;
                        end else if (rw_q) begin
                            phase_q    <= 1'b0;
                            tx_shift_q <= tx_data[6:0];
                            tx_req_q   <= 1'b1;
                            sda_oe_q   <= ~tx_data[7];
                            bit_cnt_q  <= 3'd0;
                            state_q    <= S_TX;
                        end else begin
                            phase_q  <= 1'b0;
                            sda_oe_q <= 1'b0;
                            state_q  <= S_RX;
                        end
                    end
                    S_RX: if (scl_rise_s) begin
                        shift_q   <= {shift_q[5:0], sda_f_q};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {shift_q, sda_f_q};
                            rx_valid_q <= 1'b1;
                            ack_q      <= rx_ready;
                            phase_q    <= 1'b0;
                            state_q    <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: if (scl_fall_s) begin
                        if (!phase_q) begin
                            sda_oe_q <= ack_q;
                            phase_q  <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            phase_q  <= 1'b0;
                            state_q  <= S_RX;
                        end
                    end
                    S_TX: if (scl_fall_s) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_q <= 1'b0;
                            phase_q  <= 1'b0;
                            state_q  <= S_TX_ACK;
                        end else begin
                            sda_oe_q   <= ~tx_shift_q[6];
                            tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                        end
                    end
                    S_TX_ACK: if (scl_rise_s) begin
                        if (sda_f_q) begin
                            state_q <= S_TX_DONE;
                        end else begin
                            phase_q <= 1'b1;
                        end
                    end else if (scl_fall_s && phase_q) begin
                        phase_q    <= 1'b0;
                        tx_shift_q <= tx_data[6:0];
                        tx_req_q   <= 1'b1;
                        sda_oe_q   <= ~tx_data[7];
                        bit_cnt_q  <= 3'd0;
                        state_q    <= S_TX;
                    end
                    S_TX_DONE: sda_oe_q <= 1'b0;
                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-level I2C master, transaction-level reference
// model, and a negedge monitor that scores rx_valid bytes and counts pulses.
module tb_i2c_slave_responder;
    localparam logic [6:0] ADDR = 7'h3C;
    localparam int FILT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy;
    logic [7:0] rx_data;
    logic       sda_line;

    int checks = 0, failures = 0;
    int n_start = 0, n_stop = 0, n_txreq = 0;
    int exp_start = 0, exp_stop = 0, exp_txreq = 0;
    int oe_viol = 0;
    bit oe_guard = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] supply[$];
    logic [7:0] exp_tx[$];
    logic [7:0] mon_e;

    // Reference model state: where the master is within a transaction.
    bit m_addr_phase = 1'b0, m_matched = 1'b0, m_rw = 1'b0;

    // Random-loop scratch.
    bit         r_match, r_rw;
    int         r_len;
    logic [6:0] r_addr;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_responder #(.ADDR(ADDR), .FILT(FILT)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_req(tx_req), .start_det(start_det), .stop_det(stop_det), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: scores received bytes, counts pulses, supplies transmit bytes.
    initial forever begin
        @(negedge clk);
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (oe_guard && sda_oe) oe_viol++;
        if (rx_valid) begin
            checks++;
            if (exp_rx.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
            end else begin
                mon_e = exp_rx.pop_front();
                if (rx_data !== mon_e) begin
                    failures++;
                    $display("FAIL rx_data: got %02h expected %02h", rx_data, mon_e);
                end
            end
        end
        if (tx_req) begin
            n_txreq++;
            if (supply.size() > 0) void'(supply.pop_front());
            tx_data = (supply.size() > 0) ? supply[0] : 8'($urandom);
        end
    end

    task automatic i2c_bit(input logic b, output logic s);
        sda_m = b;
        cyc(10);
        scl_m = 1'b1;
        cyc(15);
        s = sda_line;
        cyc(5);
        scl_m = 1'b0;
        cyc(10);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(10);
        scl_m = 1'b1;
        cyc(20);
        sda_m = 1'b0;
        cyc(20);
        scl_m = 1'b0;
        cyc(10);
        exp_start++;
        m_addr_phase = 1'b1;
        m_matched = 1'b0;
        oe_guard = 1'b0;
        check("start_det_count", n_start, exp_start);
        check("stop_det_count_at_start", n_stop, exp_stop);
        check("busy_after_start", {31'd0, busy}, 32'd0);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        cyc(10);
        scl_m = 1'b1;
        cyc(20);
        sda_m = 1'b1;
        cyc(20);
        exp_stop++;
        check("stop_det_count", n_stop, exp_stop);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("sda_oe_when_silent", oe_viol, 0);
        check("rx_bytes_pending", exp_rx.size(), 0);
        oe_guard = 1'b0;
        oe_viol = 0;
        m_matched = 1'b0;
        m_addr_phase = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic s;
        logic exp_ack;
        bit   was_addr;
        was_addr = m_addr_phase;
        if (m_addr_phase) begin
            m_addr_phase = 1'b0;
            m_matched = (d[7:1] == ADDR);
            m_rw = d[0];
            exp_ack = m_matched;
            if (!m_matched) oe_guard = 1'b1;
            if (m_matched && m_rw) exp_txreq++;
        end else if (m_matched && !m_rw) begin
            exp_rx.push_back(d);
            exp_ack = rx_ready;
        end else begin
            exp_ack = 1'b0;
        end
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, s);
        check(was_addr ? "addr_ack" : "data_ack", {31'd0, ~s}, {31'd0, exp_ack});
        check("busy", {31'd0, busy}, {31'd0, m_matched});
        if (was_addr) check("tx_req_count", n_txreq, exp_txreq);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] got;
        logic [7:0] want;
        logic       s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            got[i] = s;
        end
        i2c_bit(nack, s);
        want = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
        check("read_data", {24'd0, got}, {24'd0, want});
        if (nack) oe_guard = 1'b1;
        else exp_txreq++;
        check("tx_req_count", n_txreq, exp_txreq);
        check("busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic load_tx(input logic [7:0] b);
        supply.push_back(b);
        exp_tx.push_back(b);
        tx_data = supply[0];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rx_ready = 1'b1;
        tx_data = 8'h00;
        cyc(5);
        reset = 1'b0;
        cyc(2);
        check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        cyc(20);

        // Write with address match.
        rx_ready = 1'b1;
        i2c_start();
        write_byte(8'h78);
        write_byte(8'hA5);
        i2c_stop();

        // Address mismatch.
        i2c_start();
        write_byte(8'h52);
        write_byte(8'hFF);
        i2c_stop();

        // Read two bytes, ACK then NACK.
        load_tx(8'h3C);
        load_tx(8'hC3);
        i2c_start();
        write_byte(8'h79);
        read_byte(1'b0);
        read_byte(1'b1);
        i2c_stop();

        // Repeated START switching direction.
        i2c_start();
        write_byte(8'h78);
        write_byte(8'h11);
        load_tx(8'($urandom));
        i2c_start();
        write_byte(8'h79);
        read_byte(1'b1);
        i2c_stop();

        // Short SDA glitch while SCL high, then a NACKed write.
        sda_m = 1'b0;
        cyc(2);
        sda_m = 1'b1;
        cyc(30);
        check("glitch_no_start", n_start, exp_start);
        rx_ready = 1'b0;
        i2c_start();
        write_byte(8'h78);
        write_byte(8'h5A);
        i2c_stop();
        rx_ready = 1'b1;

        // Reset while the address ACK is being driven.
        i2c_start();
        begin
            logic s;
            logic [7:0] a;
            a = 8'h78;
            for (int i = 7; i >= 0; i--) i2c_bit(a[i], s);
        end
        sda_m = 1'b1;
        cyc(10);
        check("oe_before_reset", {31'd0, sda_oe}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("oe_async_reset", {31'd0, sda_oe}, 32'd0);
        cyc(2);
        reset = 1'b0;
        m_matched = 1'b0;
        m_addr_phase = 1'b0;
        oe_guard = 1'b1;
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        scl_m = 1'b1;
        cyc(20);
        scl_m = 1'b0;
        cyc(10);
        write_byte(8'($urandom));
        write_byte(8'h78);
        i2c_stop();

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            r_match = ($urandom_range(0, 3) != 0);
            r_rw    = 1'($urandom_range(0, 1));
            r_len   = $urandom_range(1, 3);
            r_addr  = 7'($urandom);
            if (r_addr == ADDR) r_addr = r_addr ^ 7'h01;
            if (r_match) r_addr = ADDR;
            if (r_match && r_rw) begin
                for (int k = 0; k < r_len; k++) load_tx(8'($urandom));
                i2c_start();
                write_byte({r_addr, 1'b1});
                for (int k = 0; k < r_len; k++) read_byte(k == r_len - 1);
            end else begin
                i2c_start();
                write_byte({r_addr, r_rw});
                for (int k = 0; k < r_len; k++) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    write_byte(8'($urandom));
                end
            end
            i2c_stop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
